// File: rtl/led_display_pwm_gen_multi_pkg.sv
// Shared types and helpers for the multi-channel LED PWM generator.
package led_display_package;

  localparam int unsigned DEFAULT_BIT_W = 8;

  typedef logic [DEFAULT_BIT_W-1:0] duty_t;

  // Clocks per counter tick. Never returns less than 1, so a fast PWM_FREQ cannot stall the counter.
  function automatic int unsigned pwm_div_calc(input longint unsigned sys_clk,
                                               input longint unsigned pwm_freq,
                                               input int unsigned     bit_w);
    longint unsigned den;
    longint unsigned quo;
    den = pwm_freq << bit_w;
    if (den == 64'd0) begin
      return 32'd1;
    end
    quo = sys_clk / den;
    return (quo == 64'd0) ? 32'd1 : 32'(quo);
  endfunction

endpackage

// File: rtl/led_display_pwm_gen_multi_tick_gen.sv
// Prescaler: one-clock tick every DIV clocks while enabled, held at 0 otherwise.
module led_pwm_tick_gen
  import led_display_package::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ     = 20_480,
  parameter int unsigned BIT_W        = 8,
  parameter int unsigned SIMULATION   = 0
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic enable_in,
  output logic tick_out
);

  localparam int unsigned DIV     = (SIMULATION != 0) ? 32'd1 :
                                    pwm_div_calc(64'(SYS_CLK_FREQ), 64'(PWM_FREQ), BIT_W);
  localparam int unsigned PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d    = pre_q;
    tick_out = 1'b0;
    if (!enable_in) begin
      pre_d = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d    = '0;
      tick_out = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/led_display_pwm_gen_multi.sv
// Multi-channel PWM generator with a shared period counter and boundary-committed duty updates.
// Optional macro LED_PWM_PHASE_STAGGER_EN spreads channel rising edges across the period.
module led_display_pwm_gen_multi
  import led_display_package::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ     = 20_480,
  parameter int unsigned BIT_W        = 8,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned SIMULATION   = 0
) (
  input  logic                    clk_in,
  input  logic                    n_reset_in,
  input  logic                    enable_in,
  input  logic [NUM_CH*BIT_W-1:0] colour_in,
  input  logic                    colour_valid_in,
  output logic                    colour_ready_out,
  output logic                    period_start_out,
  output logic [NUM_CH-1:0]       pwm_colour_out
);

  typedef logic [BIT_W-1:0] ch_duty_t;

  localparam ch_duty_t CNT_MAX = '1;

`ifdef LED_PWM_PHASE_STAGGER_EN
  function automatic ch_duty_t ch_offset(input int unsigned ch);
    return BIT_W'((64'(ch) << BIT_W) / 64'(NUM_CH));
  endfunction
`endif

  logic                    en_q;
  ch_duty_t                cnt_q,        cnt_d;
  logic [NUM_CH*BIT_W-1:0] active_q,     active_d;
  logic [NUM_CH*BIT_W-1:0] pend_q,       pend_d;
  logic                    pend_flag_q,  pend_flag_d;
  logic                    pstart_q,     pstart_d;
  logic [NUM_CH-1:0]       pwm_q,        pwm_d;

  logic     run;
  logic     tick;
  logic     boundary;
  logic     xfer;
  logic     commit;
  ch_duty_t phase;

  // The first enabled cycle is the period-start cycle, so counting begins one clock after enable rises.
  assign run = enable_in & en_q;

  led_pwm_tick_gen #(
    .SYS_CLK_FREQ (SYS_CLK_FREQ),
    .PWM_FREQ     (PWM_FREQ),
    .BIT_W        (BIT_W),
    .SIMULATION   (SIMULATION)
  ) u_tick_gen (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .enable_in  (run),
    .tick_out   (tick)
  );

  always_comb begin
    boundary = tick & (cnt_q == CNT_MAX);
    xfer     = colour_valid_in & ~pend_flag_q;
    // A transfer can only land while nothing is pending, so it never commits on the boundary it arrives on.
    commit   = pend_flag_q & (boundary | ~enable_in);

    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    pend_d      = xfer ? colour_in : pend_q;
    pend_flag_d = xfer | (pend_flag_q & ~commit);
    active_d    = commit ? pend_q : active_q;
    pstart_d    = enable_in & (~en_q | boundary);

    phase = cnt_q;
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_PWM_PHASE_STAGGER_EN
      phase = cnt_q - ch_offset(i);
`else
      phase = cnt_q;
`endif
      pwm_d[i] = run & (phase < active_q[i*BIT_W +: BIT_W]);
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      en_q        <= 1'b0;
      cnt_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      pstart_q    <= 1'b0;
      pwm_q       <= '0;
    end else begin
      en_q        <= enable_in;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      pstart_q    <= pstart_d;
      pwm_q       <= pwm_d;
    end
  end

  assign colour_ready_out = ~pend_flag_q;
  assign period_start_out = pstart_q;
  assign pwm_colour_out   = pwm_q;

endmodule

// File: tb/tb_led_display_pwm_gen_multi.sv
// Directed bench: a one-tick-per-clock instance for functional scenarios and a default-rate instance for timing.
module tb_led_display_pwm_gen_multi;

  logic        clk = 1'b0;
  logic        rst_n, en, valid, ready, pstart;
  logic [23:0] colour;
  logic [2:0]  pwm;
  logic        s_rst_n, s_en, s_valid, s_ready, s_pstart;
  logic [23:0] s_colour;
  logic [2:0]  s_pwm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_display_pwm_gen_multi #(
    .SYS_CLK_FREQ (100_000_000), .PWM_FREQ (20_480), .BIT_W (8), .NUM_CH (3), .SIMULATION (1)
  ) dut (
    .clk_in (clk), .n_reset_in (rst_n), .enable_in (en), .colour_in (colour),
    .colour_valid_in (valid), .colour_ready_out (ready),
    .period_start_out (pstart), .pwm_colour_out (pwm)
  );

  led_display_pwm_gen_multi #(
    .SYS_CLK_FREQ (100_000_000), .PWM_FREQ (20_480), .BIT_W (8), .NUM_CH (3), .SIMULATION (0)
  ) dut_slow (
    .clk_in (clk), .n_reset_in (s_rst_n), .enable_in (s_en), .colour_in (s_colour),
    .colour_valid_in (s_valid), .colour_ready_out (s_ready),
    .period_start_out (s_pstart), .pwm_colour_out (s_pwm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call on the sample where pstart is high; sample j then sees the output for counter j-1.
  task automatic run_period(input int xfer_at, input logic [23:0] xval,
                            output int h0, output int h1, output int h2, output int mids,
                            output logic endp, output logic rdy_after, output logic rdy_end);
    h0 = 0; h1 = 0; h2 = 0; mids = 0; endp = 1'b0; rdy_after = 1'b1; rdy_end = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      step();
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      h2 += int'(pwm[2]);
      if (j < 256 && pstart) mids++;
      if (j == 256) begin
        endp    = pstart;
        rdy_end = ready;
      end
      if (j == xfer_at + 1) begin
        valid     = 1'b0;
        rdy_after = ready;
      end
      if (j == xfer_at) begin
        valid  = 1'b1;
        colour = xval;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_rst_n = 1'b0; en = 1'b0; s_en = 1'b0;
    valid = 1'b0; s_valid = 1'b0; colour = '0; s_colour = '0;
    repeat (3) step();
    checks++; if (pwm !== 3'b000) begin errors++; $display("FAIL reset_pwm: got %b want 000", pwm); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (pstart !== 1'b0) begin errors++; $display("FAIL reset_pstart: got %b want 0", pstart); end
    rst_n = 1'b1; s_rst_n = 1'b1;
    repeat (5) step();
    checks++; if (pwm !== 3'b000) begin errors++; $display("FAIL idle_pwm: got %b want 000", pwm); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready); end
    checks++; if (pstart !== 1'b0) begin errors++; $display("FAIL idle_pstart: got %b want 0", pstart); end
    checks++; if (s_pwm !== 3'b000 || s_ready !== 1'b1) begin
      errors++; $display("FAIL idle_slow: got pwm=%b ready=%b want pwm=000 ready=1", s_pwm, s_ready);
    end
  endtask

  task automatic test_duty_levels();
    int h0, h1, h2, mids;
    logic endp, ra, re;
    valid = 1'b1; colour = {8'hFF, 8'h80, 8'h00};
    step();
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_pending: ready got %b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_commit: ready got %b want 1", ready); end
    en = 1'b1;
    step();
    checks++; if (pstart !== 1'b1) begin errors++; $display("FAIL en_rise_pstart: got %b want 1", pstart); end
    checks++; if (pwm !== 3'b000) begin errors++; $display("FAIL en_rise_pwm: got %b want 000", pwm); end
    for (int p = 0; p < 2; p++) begin
      run_period(-1, 24'h0, h0, h1, h2, mids, endp, ra, re);
      checks++; if (h0 != 0 || h1 != 128 || h2 != 255) begin
        errors++; $display("FAIL levels_p%0d: highs got %0d/%0d/%0d want 0/128/255", p, h0, h1, h2);
      end
      checks++; if (mids != 0 || endp !== 1'b1) begin
        errors++; $display("FAIL period_spacing_p%0d: mid pulses %0d end %b want 0 and 1", p, mids, endp);
      end
    end
  endtask

  task automatic test_mid_update();
    int h0, h1, h2, mids;
    logic endp, ra, re;
    run_period(10, 24'h404040, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 0 || h1 != 128 || h2 != 255) begin
      errors++; $display("FAIL preload_old: highs got %0d/%0d/%0d want 0/128/255", h0, h1, h2);
    end
    run_period(100, {8'hFE, 8'h01, 8'hC0}, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 64 || h1 != 64 || h2 != 64) begin
      errors++; $display("FAIL mid_keep_old: highs got %0d/%0d/%0d want 64/64/64", h0, h1, h2);
    end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b want 0", ra); end
    checks++; if (re !== 1'b1 || endp !== 1'b1) begin
      errors++; $display("FAIL mid_ready_back: ready %b pstart %b want 1 1", re, endp);
    end
    run_period(-1, 24'h0, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 192 || h1 != 1 || h2 != 254) begin
      errors++; $display("FAIL mid_new: highs got %0d/%0d/%0d want 192/1/254", h0, h1, h2);
    end
  endtask

  task automatic test_boundary_xfer();
    int h0, h1, h2, mids;
    logic endp, ra, re;
    run_period(255, {8'h20, 8'h30, 8'h40}, h0, h1, h2, mids, endp, ra, re);
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL bnd_pending: ready got %b want 0", re); end
    run_period(-1, 24'h0, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 192 || h1 != 1 || h2 != 254) begin
      errors++; $display("FAIL bnd_old_kept: highs got %0d/%0d/%0d want 192/1/254", h0, h1, h2);
    end
    checks++; if (re !== 1'b1) begin errors++; $display("FAIL bnd_ready_back: got %b want 1", re); end
    run_period(-1, 24'h0, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 64 || h1 != 48 || h2 != 32) begin
      errors++; $display("FAIL bnd_new: highs got %0d/%0d/%0d want 64/48/32", h0, h1, h2);
    end
  endtask

  task automatic test_enable_drop();
    int h0, h1, h2, mids, np, nh;
    logic endp, ra, re;
    repeat (50) step();
    checks++; if (pwm !== 3'b001) begin errors++; $display("FAIL pre_drop_pwm: got %b want 001", pwm); end
    en = 1'b0;
    step();
    checks++; if (pwm !== 3'b000) begin errors++; $display("FAIL drop_pwm: got %b want 000", pwm); end
    np = 0; nh = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (pstart) np++;
      if (pwm != 3'b000) nh++;
    end
    checks++; if (np != 0 || nh != 0) begin
      errors++; $display("FAIL disabled_idle: pulses %0d high samples %0d want 0 0", np, nh);
    end
    valid = 1'b1; colour = {8'h10, 8'h90, 8'hF0};
    step();
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dis_xfer: ready got %b want 0", ready); end
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL dis_commit: ready got %b want 1", ready); end
    en = 1'b1;
    step();
    checks++; if (pstart !== 1'b1) begin errors++; $display("FAIL reen_pstart: got %b want 1", pstart); end
    run_period(-1, 24'h0, h0, h1, h2, mids, endp, ra, re);
    checks++; if (h0 != 240 || h1 != 144 || h2 != 16) begin
      errors++; $display("FAIL reen_period: highs got %0d/%0d/%0d want 240/144/16", h0, h1, h2);
    end
    checks++; if (mids != 0 || endp !== 1'b1) begin
      errors++; $display("FAIL reen_spacing: mid pulses %0d end %b want 0 1", mids, endp);
    end
  endtask

  task automatic test_slow_rate();
    int h0, h1, h2, mids, wait_n;
    logic endp;
    s_valid = 1'b1; s_colour = {8'h00, 8'h01, 8'h80};
    step();
    s_valid = 1'b0;
    step();
    s_en = 1'b1;
    wait_n = 0;
    do begin
      step();
      wait_n++;
    end while (!s_pstart && wait_n < 20);
    checks++; if (wait_n != 1) begin errors++; $display("FAIL slow_start: pulse after %0d cycles want 1", wait_n); end
    h0 = 0; h1 = 0; h2 = 0; mids = 0; endp = 1'b0;
    for (int j = 1; j <= 4864; j++) begin
      step();
      h0 += int'(s_pwm[0]);
      h1 += int'(s_pwm[1]);
      h2 += int'(s_pwm[2]);
      if (j < 4864 && s_pstart) mids++;
      if (j == 4864) endp = s_pstart;
    end
    checks++; if (mids != 0 || endp !== 1'b1) begin
      errors++; $display("FAIL slow_period: mid pulses %0d end %b want 0 1 at 4864", mids, endp);
    end
    checks++; if (h0 != 2432 || h1 != 19 || h2 != 0) begin
      errors++; $display("FAIL slow_highs: got %0d/%0d/%0d want 2432/19/0", h0, h1, h2);
    end
    repeat (99) step();
    s_valid = 1'b1; s_colour = 24'h123456;
    step();
    s_valid = 1'b0;
    checks++; if (s_pwm !== 3'b001 || s_ready !== 1'b0) begin
      errors++; $display("FAIL slow_mid: pwm %b ready %b want 001 0", s_pwm, s_ready);
    end
    #2;
    s_rst_n = 1'b0;
    #1;
    checks++; if (s_pwm !== 3'b000 || s_ready !== 1'b1 || s_pstart !== 1'b0) begin
      errors++; $display("FAIL async_reset: pwm %b ready %b pstart %b want 000 1 0", s_pwm, s_ready, s_pstart);
    end
    step();
    s_rst_n = 1'b1;
    s_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty_levels();
    test_mid_update();
    test_boundary_xfer();
    test_enable_drop();
    test_slow_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
